// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit arbiter.
`timescale 1ns/1ps
package uart_tx_pkg;

    localparam int         BYTE_W     = 8;
    localparam logic [3:0] TAG_NIBBLE = 4'hA;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        DRAIN = 2'd2
    } tx_arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the winner is the first set request
// found searching upward from pointer+1, wrapping to bit 0.
`timescale 1ns/1ps
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic          any
);

    localparam logic [N-1:0] ONE = N'(1);
    localparam logic [N-1:0] TWO = N'(2);

    logic [N-1:0] above_mask;
    logic [N-1:0] req_hi;
    logic [N-1:0] pick_src;

    // Prefer requests above the pointer; otherwise wrap and take the lowest set bit.
    always_comb begin
        above_mask = ~((TWO << pointer) - ONE);
        req_hi     = req & above_mask;
        pick_src   = (|req_hi) ? req_hi : req;
        grant      = pick_src & (~pick_src + ONE);
        any        = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART transmitter between several word-reporting
// sources: round-robin grant, capture, then a tagged MSB-first byte stream.
//
// state | meaning
// IDLE  | sampling req; a winner is acked and its first byte written
// ARM   | write issued, waiting for tx_busy to rise (or timeout)
// DRAIN | UART busy, waiting for tx_busy to fall before the next byte
`timescale 1ns/1ps
module uart_tx_arbiter
    import uart_tx_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WORD_BYTES  = 4,
    parameter int SEND_ID     = 1,
    parameter int ARM_TIMEOUT = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*WORD_BYTES*8-1:0] req_word,
    output logic [NUM_REQ-1:0]              ack,
    output logic [7:0]                      tx_data,
    output logic                            tx_wr_en,
    input  logic                            tx_busy,
    output logic                            frame_active,
    output logic [15:0]                     frames_sent
);

    localparam int         PW          = $clog2(NUM_REQ);
    localparam int         WORD_W      = WORD_BYTES * BYTE_W;
    localparam logic [3:0] BYTES_TOTAL = 4'(WORD_BYTES + SEND_ID);
    localparam logic [7:0] TMO_LOAD    = 8'(ARM_TIMEOUT);

    tx_arb_state_t       state, state_next;
    logic [PW-1:0]       pointer;
    logic [NUM_REQ-1:0]  grant;
    logic                any_req;
    logic [PW-1:0]       win_idx;
    logic [WORD_W-1:0]   word_sel;
    logic [WORD_W-1:0]   shreg;
    logic [3:0]          bytes_left;
    logic [7:0]          tmo_cnt;
    logic                do_grant, do_next, do_finish, tmo_dec, byte_done;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (req),
        .pointer (pointer),
        .grant   (grant),
        .any     (any_req)
    );

    // Encode the one-hot grant and select the winner's word.
    always_comb begin
        win_idx  = '0;
        word_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_idx  = PW'(i);
                word_sel = req_word[i*WORD_W +: WORD_W];
            end
        end
    end

    // Next-state and datapath control; an ARM timeout is treated like a busy fall.
    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_next    = 1'b0;
        do_finish  = 1'b0;
        tmo_dec    = 1'b0;
        byte_done  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    do_grant   = 1'b1;
                    state_next = ARM;
                end
            end
            ARM: begin
                if (tx_busy)
                    state_next = DRAIN;
                else if (tmo_cnt == 8'd1)
                    byte_done = 1'b1;
                else
                    tmo_dec = 1'b1;
            end
            DRAIN: begin
                if (!tx_busy)
                    byte_done = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        if (byte_done) begin
            if (bytes_left == 4'd1) begin
                do_finish  = 1'b1;
                state_next = IDLE;
            end else begin
                do_next    = 1'b1;
                state_next = ARM;
            end
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Registered outputs, shift register, byte and timeout counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pointer      <= PW'(NUM_REQ - 1);
            ack          <= '0;
            tx_data      <= '0;
            tx_wr_en     <= 1'b0;
            frame_active <= 1'b0;
            frames_sent  <= '0;
            shreg        <= '0;
            bytes_left   <= '0;
            tmo_cnt      <= '0;
        end else begin
            ack      <= do_grant ? grant : '0;
            tx_wr_en <= do_grant | do_next;
            if (do_grant) begin
                pointer      <= win_idx;
                frame_active <= 1'b1;
                bytes_left   <= BYTES_TOTAL;
                tmo_cnt      <= TMO_LOAD;
                // With a tag the whole word stays queued; without one the MSB goes out now.
                if (SEND_ID != 0) begin
                    tx_data <= {TAG_NIBBLE, 4'(win_idx)};
                    shreg   <= word_sel;
                end else begin
                    tx_data <= word_sel[WORD_W-1 -: BYTE_W];
                    shreg   <= word_sel << BYTE_W;
                end
            end
            if (do_next) begin
                tx_data    <= shreg[WORD_W-1 -: BYTE_W];
                shreg      <= shreg << BYTE_W;
                bytes_left <= bytes_left - 4'd1;
                tmo_cnt    <= TMO_LOAD;
            end
            if (tmo_dec)
                tmo_cnt <= tmo_cnt - 8'd1;
            if (do_finish) begin
                frame_active <= 1'b0;
                frames_sent  <= frames_sent + 16'd1;
                bytes_left   <= '0;
            end
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single byte-wide UART transmitter among several result sources, for example multiple hashing cores that each report a found nonce. It arbitrates round-robin between requesters and captures the winning word. It then sequences the word out as a framed byte stream, optionally prefixed with a tag byte, pacing each byte on the UART's `wr_en`/`tx_busy` handshake. It sits between the miner cores and the UART transmit port.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `WORD_BYTES`, 4: bytes per reported word, 1..8.
- `SEND_ID`, 1: when 1, prefix each frame with a tag byte.
- `ARM_TIMEOUT`, 4: cycles to wait for `tx_busy` to rise after a write, 2..255.

- `clock`, in, 1: single clock; all logic on its rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `req`, in, NUM_REQ: per-requester level request; held until acked.
- `req_word`, in, NUM_REQ*WORD_BYTES*8: requester i's word at slice i; must be stable while `req[i]`=1.
- `ack`, out, NUM_REQ: one-hot, one-cycle pulse; word captured.
- `tx_data`, out, 8: byte to the UART `din`.
- `tx_wr_en`, out, 1: one-cycle write strobe to the UART.
- `tx_busy`, in, 1: UART transmitter busy.
- `frame_active`, out, 1: high from grant until the last byte drains.
- `frames_sent`, out, 16: count of completed frames; wraps at 16'hFFFF→0.

## Operation
- FSM states are IDLE, ARM and DRAIN.
- Reset values: state=IDLE, `ack`=0, `tx_data`=0, `tx_wr_en`=0, `frame_active`=0, `frames_sent`=0, round-robin pointer=NUM_REQ-1 (req 0 has first priority).

**IDLE**
- `req` is sampled only in IDLE.
- If any bit is set, the winner is the first set bit searching from pointer+1 with wrap.
- On that edge the block registers:
  - `ack[winner]`=1, pointer=winner, word→shift register, `frame_active`=1.
  - Byte count = WORD_BYTES+SEND_ID.
  - `tx_data` = tag {4'hA, winner[3:0]} if SEND_ID, else word[MSB byte]; `tx_wr_en`=1.
  - State → ARM.

**ARM**
- `tx_wr_en` is forced to 0, so the strobe is exactly one cycle.
- `tx_busy`=1 → DRAIN.
- If `tx_busy` has not risen after ARM_TIMEOUT cycles in ARM, the byte counts as sent and the block behaves as if DRAIN saw `tx_busy`=0.

**DRAIN**
- Waits for `tx_busy`=0.
- If bytes remain: shift the word left 8, present the next byte (MSB first), pulse `tx_wr_en`, → ARM.
- On the last byte: `frame_active`=0, `frames_sent`++, → IDLE.

**Requester handshake**
- A requester must drop `req` by the cycle after its `ack`.
- A `req` still high when the FSM next reaches IDLE is re-granted as a new frame. This is legal, not an error.

**Boundary conditions**
- Simultaneous requests: strict round-robin, so no requester is granted twice while another waits.
- `req` changing outside IDLE: ignored.
- `tx_busy` already high in IDLE: ignored. The first write still issues, and ARM sees busy immediately.
- `reset` mid-frame:
  - All outputs return to reset values immediately; the frame is abandoned.
  - No further `ack` is issued for it, and `frames_sent` is cleared.

## Timing
- Grant latency: `req` high in IDLE at cycle N → `ack`, `tx_wr_en` and first byte valid at cycle N+1.
- `tx_wr_en` is never high on two consecutive cycles.
- Minimum frame time is (WORD_BYTES+SEND_ID)×(2 + UART byte time) cycles, plus one IDLE cycle between frames.
- `frames_sent` updates on the same edge that enters IDLE.
- All outputs are registered; no combinational path from `req` or `tx_busy` to any output.

## Structure
- Package `uart_tx_pkg` holds:
  - the state enum `tx_arb_state_t` (IDLE, ARM, DRAIN);
  - `TAG_NIBBLE` = 4'hA;
  - `BYTE_W` = 8.
- Sub-module `rr_arbiter` (parameter N): inputs `req` and `pointer`; outputs one-hot `grant` and `any`. It is purely combinational.
- The FSM, shift register, byte and timeout counters, and `frames_sent` live in the top module.

## Test plan
- **Single request:**
  - Stimulus: `req`=4'b0001, word 32'hDEADBEEF, UART model busy 10 cycles per byte.
  - Response: bytes A0, DE, AD, BE, EF in order; one `ack[0]` pulse; `frames_sent`=1.
- **Contention:**
  - Stimulus: `req`=4'b1111 held, each requester dropping `req` after its `ack`.
  - Response: grant order 0, 1, 2, 3; tags A0, A1, A2, A3.
- **Fairness:**
  - Stimulus: req 0 and req 2 reasserted immediately after each ack.
  - Response: grants alternate 0, 2, 0, 2.
- **Timeout:**
  - Stimulus: UART model never raises `tx_busy`.
  - Response: each byte advances after ARM_TIMEOUT cycles; frame completes; `frames_sent` increments.
- **Reset mid-frame:**
  - Stimulus: assert `reset` during the third byte of a frame.
  - Response: `tx_wr_en`=0 and `frame_active`=0 asynchronously; after release, req 0 has priority again.
- **No tag:**
  - Stimulus: SEND_ID=0, WORD_BYTES=2, word 16'h1234.
  - Response: exactly two writes, bytes 12 then 34.
